fifo_traffic_master: RTL and testbench
======================================

Name: fifo_traffic_master

Overview:
Synthesizable initiator that drives the FIFO write/read side (data_in, wr_en, rd_en) and checks everything the FIFO returns (data_out, wr_ack, overflow, underflow).
- Executes commands (write burst, read burst, concurrent mixed) with an incrementing data pattern.
- Self-checks returned data and write acknowledges in order.
- Counts errors and overflow/underflow events.
- Used as on-chip BIST and as a reusable bench driver on the FIFO's tb side.

Parameters:
FIFO_WIDTH, 16, data_in/data_out width.
FIFO_DEPTH, 8, depth of the attached FIFO; used only by the test plan, no RTL logic depends on it.
LEN_W, 8, width of burst length fields.
CNT_W, 16, width of status counters.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  high in IDLE only; command taken when cmd_valid&&cmd_ready
cmd_op  input  2  00 WRITE, 01 READ, 10 MIXED, 11 NOP
cmd_wlen  input  LEN_W  writes to issue (WRITE/MIXED)
cmd_rlen  input  LEN_W  reads to issue (READ/MIXED)
cmd_force  input  1  1: ignore full/empty gating to provoke overflow/underflow
data_in  output  FIFO_WIDTH  write data to FIFO, equals wr_pat
wr_en  output  1  write request to FIFO
rd_en  output  1  read request to FIFO
data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after an accepted read
wr_ack, overflow, underflow  input  1 each  FIFO registered status, one cycle after the request edge
full, empty  input  1 each  FIFO combinational status, same cycle
almostfull, almostempty  input  1 each  unused; no behaviour depends on them
busy  output  1  state != IDLE
done  output  1  one-cycle pulse at command completion
err_cnt  output  CNT_W  data plus wr_ack mismatches, saturating
ovf_cnt  output  CNT_W  cycles with overflow=1 while busy, saturating
udf_cnt  output  CNT_W  cycles with underflow=1 while busy, saturating

Behaviour:
Reset (async, rst_n=0):
- State=IDLE.
- wr_en, rd_en, done, busy = 0; cmd_ready=1; data_in=0.
- wr_pat, rd_pat, wrem, rrem = 0; all counters = 0.
- Reset mid-command aborts with no done pulse.

States: IDLE -> RUN on command accept -> DRAIN (exactly 1 cycle) -> DONE (1 cycle, done=1) -> IDLE.
- Command accept latches wrem/rrem per op: WRITE uses wlen only, READ uses rlen only, MIXED uses both, NOP uses neither. Also latches force.
- RUN exits when wrem==0 && rrem==0. Zero-length commands and NOP go RUN -> DRAIN on the next cycle.

Request generation (combinational outputs, RUN only):
- wr_en = (wrem!=0) && (force || !full).
- rd_en = (rrem!=0) && (force || !empty).
- In MIXED, both may assert in the same cycle.

Per-edge updates:
- wr_fire = wr_en && !full. On wr_fire: wr_pat+1 (wraps modulo 2^FIFO_WIDTH).
- rd_fire = rd_en && !empty. On rd_fire: rd_pat+1; exp <= rd_pat; chk_pend <= 1 (else 0).
- wrem decrements on every wr_en edge; rrem decrements on every rd_en edge. In force mode, rejected attempts consume length.

Checking:
- Next cycle after any edge: if chk_pend && data_out != exp, err_cnt+1.
- ack_exp <= wr_fire. Next cycle: if wr_ack != ack_exp, err_cnt+1. Data and ack errors in the same cycle add 2.
- In RUN and DRAIN: overflow=1 gives ovf_cnt+1; underflow=1 gives udf_cnt+1.
- DRAIN exists so the final read/ack/flag response is checked and counted.

Other rules:
- wr_pat and rd_pat persist across commands and reset only via rst_n, so data written by one command and read by a later one still checks in order.
- All counters saturate at 2^CNT_W-1.
- cmd_* inputs are ignored outside IDLE.
- Non-force WRITE longer than free space stalls in RUN until another agent reads; stalling is intended.

Test Plan:
1. Reset asserted mid-RUN -> same cycle: wr_en=rd_en=0, busy=0, cmd_ready=1, counters=0; after release, a WRITE 1 drives data_in=0.
2. WRITE wlen=8 then READ rlen=8, DEPTH=8 FIFO -> data 0..7 written and read back, 8 wr_ack, err_cnt=0, ovf_cnt=udf_cnt=0, done pulses twice.
3. MIXED wlen=20 rlen=20 from empty -> completes, wr_pat=rd_pat=20, err_cnt=0, never overflow/underflow.
4. Force WRITE wlen=10 into empty FIFO -> 8 wr_ack, ovf_cnt=2, err_cnt=0, wr_pat=8; then READ rlen=8 reads 0..7, err_cnt=0.
5. Force READ rlen=3 on empty -> udf_cnt=3, rd_pat unchanged, err_cnt=0; NOP -> done 3 cycles after accept, no requests.
6. Bench flips data_out bit 0 on the 3rd read of READ 8 -> err_cnt=1; dropping wr_ack once during WRITE 4 -> err_cnt+1.

Source files
------------

// File: rtl/fifo_traffic_master.sv
// fifo_traffic_master: command-driven FIFO initiator that writes an incrementing
// pattern, checks read data and write acks in order, and counts flag events.
module fifo_traffic_master #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LEN_W-1:0]      cmd_wlen,
  input  logic [LEN_W-1:0]      cmd_rlen,
  input  logic                  cmd_force,
  output logic [FIFO_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  input  logic [FIFO_WIDTH-1:0] data_out,
  input  logic                  wr_ack,
  input  logic                  overflow,
  input  logic                  underflow,
  input  logic                  full,
  input  logic                  empty,
  input  logic                  almostfull,
  input  logic                  almostempty,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]      ovf_cnt,
  output logic [CNT_W-1:0]      udf_cnt
);

  localparam logic [1:0] OP_WRITE = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_MIXED = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [LEN_W-1:0]        wrem_q, wrem_d, rrem_q, rrem_d;
  logic                    force_q, force_d;
  logic [FIFO_WIDTH-1:0]   wr_pat_q, wr_pat_d, rd_pat_q, rd_pat_d, exp_q, exp_d;
  logic                    chk_pend_q, chk_pend_d, ack_exp_q, ack_exp_d;
  logic [CNT_W-1:0]        err_cnt_q, err_cnt_d, ovf_cnt_q, ovf_cnt_d, udf_cnt_q, udf_cnt_d;
  logic                    busy_q, busy_d, done_q, done_d, cmd_ready_q, cmd_ready_d;
  logic                    wr_req, rd_req, wr_fire, rd_fire, data_err, ack_err, flag_win;
  logic [1:0]              err_inc;
  logic                    unused_inputs;

  // Watermark flags and the depth are informational only.
  assign unused_inputs = ^{almostfull, almostempty, FIFO_DEPTH[0]};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  always_comb begin
    wr_req   = (state_q == S_RUN) && (wrem_q != '0) && (force_q || !full);
    rd_req   = (state_q == S_RUN) && (rrem_q != '0) && (force_q || !empty);
    wr_fire  = wr_req && !full;
    rd_fire  = rd_req && !empty;
    data_err = chk_pend_q && (data_out != exp_q);
    ack_err  = (wr_ack != ack_exp_q);
    err_inc  = {1'b0, data_err} + {1'b0, ack_err};
    flag_win = (state_q == S_RUN) || (state_q == S_DRAIN);

    state_d    = state_q;
    wrem_d     = wrem_q;
    rrem_d     = rrem_q;
    force_d    = force_q;
    wr_pat_d   = wr_fire ? wr_pat_q + FIFO_WIDTH'(1) : wr_pat_q;
    rd_pat_d   = rd_fire ? rd_pat_q + FIFO_WIDTH'(1) : rd_pat_q;
    exp_d      = rd_fire ? rd_pat_q : exp_q;
    chk_pend_d = rd_fire;
    ack_exp_d  = wr_fire;
    err_cnt_d  = sat_add(err_cnt_q, err_inc);
    ovf_cnt_d  = sat_add(ovf_cnt_q, {1'b0, flag_win && overflow});
    udf_cnt_d  = sat_add(udf_cnt_q, {1'b0, flag_win && underflow});

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_RUN;
          force_d = cmd_force;
          wrem_d  = (cmd_op == OP_WRITE || cmd_op == OP_MIXED) ? cmd_wlen : '0;
          rrem_d  = (cmd_op == OP_READ  || cmd_op == OP_MIXED) ? cmd_rlen : '0;
        end
      end
      S_RUN: begin
        // Every issued request consumes length, even one the FIFO rejects.
        if (wr_req) wrem_d = wrem_q - LEN_W'(1);
        if (rd_req) rrem_d = rrem_q - LEN_W'(1);
        if (wrem_q == '0 && rrem_q == '0) state_d = S_DRAIN;
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
    cmd_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wrem_q      <= '0;
      rrem_q      <= '0;
      force_q     <= 1'b0;
      wr_pat_q    <= '0;
      rd_pat_q    <= '0;
      exp_q       <= '0;
      chk_pend_q  <= 1'b0;
      ack_exp_q   <= 1'b0;
      err_cnt_q   <= '0;
      ovf_cnt_q   <= '0;
      udf_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      wrem_q      <= wrem_d;
      rrem_q      <= rrem_d;
      force_q     <= force_d;
      wr_pat_q    <= wr_pat_d;
      rd_pat_q    <= rd_pat_d;
      exp_q       <= exp_d;
      chk_pend_q  <= chk_pend_d;
      ack_exp_q   <= ack_exp_d;
      err_cnt_q   <= err_cnt_d;
      ovf_cnt_q   <= ovf_cnt_d;
      udf_cnt_q   <= udf_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign data_in   = wr_pat_q;
  assign wr_en     = wr_req;
  assign rd_en     = rd_req;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_ready = cmd_ready_q;
  assign err_cnt   = err_cnt_q;
  assign ovf_cnt   = ovf_cnt_q;
  assign udf_cnt   = udf_cnt_q;

endmodule

// File: tb/tb_fifo_traffic_master.sv
// Bench for fifo_traffic_master: a behavioural FIFO with fault injection on the
// far side, plus a transaction-level model predicting counters and write data.
`timescale 1ns/1ps
module tb_fifo_traffic_master;
  localparam int W = 16, DEPTH = 8, LEN_W = 8, CNT_W = 16;
  localparam logic [1:0] OP_WRITE = 2'd0, OP_READ = 2'd1, OP_MIXED = 2'd2, OP_NOP = 2'd3;
  localparam logic [W-1:0] BIT0 = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_force = 1'b0, cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [LEN_W-1:0] cmd_wlen = '0, cmd_rlen = '0;
  logic [W-1:0] data_in, data_out;
  logic wr_en, rd_en, wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic busy, done;
  logic [CNT_W-1:0] err_cnt, ovf_cnt, udf_cnt;

  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  fifo_traffic_master #(.FIFO_WIDTH(W), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_wlen(cmd_wlen), .cmd_rlen(cmd_rlen), .cmd_force(cmd_force), .data_in(data_in),
    .wr_en(wr_en), .rd_en(rd_en), .data_out(data_out), .wr_ack(wr_ack), .overflow(overflow),
    .underflow(underflow), .full(full), .empty(empty), .almostfull(almostfull),
    .almostempty(almostempty), .busy(busy), .done(done), .err_cnt(err_cnt),
    .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
  );

  // Behavioural FIFO: registered flags/data, combinational full/empty.
  logic [W-1:0] mem [DEPTH];
  int wp, rp, fcount, n_wr, n_rd;
  int flip_at = -1, drop_at = -1;
  logic [W-1:0] wlog [$];

  assign full        = (fcount == DEPTH);
  assign empty       = (fcount == 0);
  assign almostfull  = (fcount == DEPTH - 1);
  assign almostempty = (fcount == 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= 0; rp <= 0; fcount <= 0; n_wr <= 0; n_rd <= 0;
      wr_ack <= 1'b0; overflow <= 1'b0; underflow <= 1'b0; data_out <= '0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      wr_ack    <= wr_en && !full && (n_wr != drop_at);
      if (wr_en && !full) begin
        mem[wp] <= data_in;
        wp <= (wp + 1) % DEPTH;
        n_wr <= n_wr + 1;
        wlog.push_back(data_in);
      end
      if (rd_en && !empty) begin
        data_out <= (n_rd == flip_at) ? (mem[rp] ^ BIT0) : mem[rp];
        rp <= (rp + 1) % DEPTH;
        n_rd <= n_rd + 1;
      end
      fcount <= fcount + ((wr_en && !full) ? 1 : 0) - ((rd_en && !empty) ? 1 : 0);
    end
  end

  // Reference model state and per-command observations.
  int m_cnt, m_ovf, m_udf, m_err;
  logic [W-1:0] m_wr, wr_base;
  int exp_w, exp_r, exp_aw, exp_ar;
  int obs_wc, obs_rc, obs_dn, obs_done_at;

  task automatic reset_model();
    m_cnt = 0; m_ovf = 0; m_udf = 0; m_err = 0; m_wr = '0;
    flip_at = -1; drop_at = -1;
    wlog.delete();
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    reset_model();
  endtask

  // Forced commands attempt a request every cycle while length remains;
  // unforced ones (kept within occupancy by the caller) are all accepted.
  task automatic model_cmd(input logic [1:0] op, input int w_in, input int r_in, input logic frc);
    exp_w = (op == OP_WRITE || op == OP_MIXED) ? w_in : 0;
    exp_r = (op == OP_READ || op == OP_MIXED) ? r_in : 0;
    exp_aw = 0; exp_ar = 0;
    if (!frc) begin
      exp_aw = exp_w; exp_ar = exp_r;
      m_cnt = m_cnt + exp_w - exp_r;
    end else begin
      for (int i = 0; i < ((exp_w > exp_r) ? exp_w : exp_r); i++) begin
        bit wa, ra;
        wa = (i < exp_w) && (m_cnt < DEPTH);
        ra = (i < exp_r) && (m_cnt > 0);
        if (i < exp_w && !wa) m_ovf++;
        if (i < exp_r && !ra) m_udf++;
        if (wa) begin exp_aw++; m_cnt++; end
        if (ra) begin exp_ar++; m_cnt--; end
      end
    end
  endtask

  task automatic issue_cmd(input logic [1:0] op, input int w, input int r, input logic frc);
    @(posedge clk); #1;
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready_idle: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_force = frc;
    cmd_wlen = LEN_W'(w); cmd_rlen = LEN_W'(r);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cmd(input bit junk);
    bit fin;
    int n;
    fin = 0; n = 0;
    obs_wc = 0; obs_rc = 0; obs_dn = 0; obs_done_at = 0;
    while (n < 2000 && !fin) begin
      @(negedge clk); n++;
      if (wr_en) obs_wc++;
      if (rd_en) obs_rc++;
      if (done) begin obs_dn++; if (obs_done_at == 0) obs_done_at = n; end
      if (cmd_ready) fin = 1;
      else if (junk) begin
        cmd_valid = 1'($urandom()); cmd_op = 2'($urandom()); cmd_force = 1'($urandom());
        cmd_wlen = LEN_W'($urandom()); cmd_rlen = LEN_W'($urandom());
      end
    end
    cmd_valid = 1'b0;
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL cmd_timeout: busy after %0d cycles, want return to idle", n);
    end
  endtask

  task automatic do_cmd(input logic [1:0] op, input int w, input int r, input logic frc, input bit junk);
    wr_base = m_wr;
    model_cmd(op, w, r, frc);
    wlog.delete();
    issue_cmd(op, w, r, frc);
    wait_cmd(junk);
    m_wr = m_wr + W'(exp_aw);
    $display("cmd op=%0d wlen=%0d rlen=%0d force=%0b: wr_en=%0d rd_en=%0d writes=%0d done=%0d err=%0d ovf=%0d udf=%0d",
             op, w, r, frc, obs_wc, obs_rc, wlog.size(), obs_dn, err_cnt, ovf_cnt, udf_cnt);
  endtask

  task automatic test_reset();
    bit saw_done;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, done, wr_en, rd_en} !== 5'b10000) begin
      miscompares++; $display("FAIL reset_ctrl: got %b want 10000", {cmd_ready, busy, done, wr_en, rd_en});
    end
    vectors++;
    if ({err_cnt, ovf_cnt, udf_cnt, data_in} !== '0) begin
      miscompares++; $display("FAIL reset_data: got %h want 0", {err_cnt, ovf_cnt, udf_cnt, data_in});
    end
    #2 rst_n = 1'b1;
    reset_model();
    do_cmd(OP_READ, 0, 2, 1'b1, 1'b0);
    vectors++;
    if (udf_cnt !== CNT_W'(2)) begin miscompares++; $display("FAIL pre_reset_udf: got %0d want 2", udf_cnt); end
    issue_cmd(OP_WRITE, 5, 0, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({busy, wr_en} !== 2'b11) begin miscompares++; $display("FAIL mid_run: got %b want 11", {busy, wr_en}); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({cmd_ready, busy, done, wr_en, rd_en} !== 5'b10000) begin
      miscompares++; $display("FAIL abort_ctrl: got %b want 10000", {cmd_ready, busy, done, wr_en, rd_en});
    end
    vectors++;
    if ({err_cnt, ovf_cnt, udf_cnt, data_in} !== '0) begin
      miscompares++; $display("FAIL abort_data: got %h want 0", {err_cnt, ovf_cnt, udf_cnt, data_in});
    end
    saw_done = 0;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    #2 rst_n = 1'b1;
    reset_model();
    repeat (3) begin @(negedge clk); if (done) saw_done = 1; end
    vectors++;
    if (saw_done) begin miscompares++; $display("FAIL abort_done: got pulse want none"); end
    do_cmd(OP_WRITE, 1, 0, 1'b0, 1'b0);
    vectors++;
    if (wlog.size() != 1) begin miscompares++; $display("FAIL restart_count: got %0d want 1", wlog.size()); end
    else if (wlog[0] !== '0) begin miscompares++; $display("FAIL restart_data: got %h want 0", wlog[0]); end
  endtask

  task automatic test_write_read();
    do_reset();
    do_cmd(OP_WRITE, 8, 5, 1'b0, 1'b0);
    vectors++;
    if (obs_dn != 1 || obs_wc != 8) begin miscompares++; $display("FAIL wr8_done_wen: got %0d/%0d want 1/8", obs_dn, obs_wc); end
    vectors++;
    if (wlog.size() != 8) begin miscompares++; $display("FAIL wr8_count: got %0d want 8", wlog.size()); end
    for (int k = 0; k < wlog.size(); k++) begin
      vectors++;
      if (wlog[k] !== W'(k)) begin miscompares++; $display("FAIL wr8_data[%0d]: got %h want %h", k, wlog[k], W'(k)); end
    end
    do_cmd(OP_READ, 3, 8, 1'b0, 1'b0);
    vectors++;
    if (obs_dn != 1 || obs_rc != 8) begin miscompares++; $display("FAIL rd8_done_ren: got %0d/%0d want 1/8", obs_dn, obs_rc); end
    vectors++;
    if ({err_cnt, ovf_cnt, udf_cnt} !== '0) begin
      miscompares++; $display("FAIL rd8_counters: got err %0d ovf %0d udf %0d want 0 0 0", err_cnt, ovf_cnt, udf_cnt);
    end
  endtask

  task automatic test_mixed();
    do_reset();
    do_cmd(OP_MIXED, 20, 20, 1'b0, 1'b0);
    vectors++;
    if (obs_dn != 1 || obs_wc != 20 || obs_rc != 20) begin
      miscompares++; $display("FAIL mixed_reqs: got done %0d wr %0d rd %0d want 1 20 20", obs_dn, obs_wc, obs_rc);
    end
    vectors++;
    if (data_in !== W'(20)) begin miscompares++; $display("FAIL mixed_wr_pat: got %0d want 20", data_in); end
    vectors++;
    if ({err_cnt, ovf_cnt, udf_cnt} !== '0) begin
      miscompares++; $display("FAIL mixed_counters: got err %0d ovf %0d udf %0d want 0 0 0", err_cnt, ovf_cnt, udf_cnt);
    end
    do_cmd(OP_WRITE, 1, 0, 1'b0, 1'b0);
    do_cmd(OP_READ, 0, 1, 1'b0, 1'b0);
    vectors++;
    if (err_cnt !== '0) begin miscompares++; $display("FAIL mixed_rd_pat: got err %0d want 0", err_cnt); end
  endtask

  task automatic test_force_overflow();
    do_reset();
    do_cmd(OP_WRITE, 10, 0, 1'b1, 1'b0);
    vectors++;
    if (obs_wc != 10 || wlog.size() != 8) begin
      miscompares++; $display("FAIL fovf_writes: got wr_en %0d accepted %0d want 10 8", obs_wc, wlog.size());
    end
    vectors++;
    if (ovf_cnt !== CNT_W'(2)) begin miscompares++; $display("FAIL fovf_ovf: got %0d want 2", ovf_cnt); end
    vectors++;
    if (data_in !== W'(8)) begin miscompares++; $display("FAIL fovf_wr_pat: got %0d want 8", data_in); end
    do_cmd(OP_READ, 0, 8, 1'b0, 1'b0);
    vectors++;
    if (err_cnt !== '0 || udf_cnt !== '0) begin
      miscompares++; $display("FAIL fovf_readback: got err %0d udf %0d want 0 0", err_cnt, udf_cnt);
    end
  endtask

  task automatic test_force_underflow_nop();
    do_reset();
    do_cmd(OP_READ, 0, 3, 1'b1, 1'b0);
    vectors++;
    if (udf_cnt !== CNT_W'(3) || obs_rc != 3) begin
      miscompares++; $display("FAIL fudf: got udf %0d rd_en %0d want 3 3", udf_cnt, obs_rc);
    end
    do_cmd(OP_WRITE, 2, 0, 1'b0, 1'b0);
    do_cmd(OP_READ, 0, 2, 1'b0, 1'b0);
    vectors++;
    if (err_cnt !== '0) begin miscompares++; $display("FAIL fudf_rd_pat: got err %0d want 0", err_cnt); end
    do_cmd(OP_NOP, 7, 9, 1'b1, 1'b0);
    vectors++;
    if (obs_done_at != 3 || obs_dn != 1) begin
      miscompares++; $display("FAIL nop_done: got cycle %0d pulses %0d want 3 1", obs_done_at, obs_dn);
    end
    vectors++;
    if (obs_wc != 0 || obs_rc != 0) begin miscompares++; $display("FAIL nop_reqs: got %0d/%0d want 0/0", obs_wc, obs_rc); end
  endtask

  task automatic test_fault_inject();
    do_reset();
    do_cmd(OP_WRITE, 8, 0, 1'b0, 1'b0);
    flip_at = n_rd + 2;
    do_cmd(OP_READ, 0, 8, 1'b0, 1'b0);
    vectors++;
    if (err_cnt !== CNT_W'(1)) begin miscompares++; $display("FAIL inject_data: got err %0d want 1", err_cnt); end
    drop_at = n_wr + 1;
    do_cmd(OP_WRITE, 4, 0, 1'b0, 1'b0);
    vectors++;
    if (err_cnt !== CNT_W'(2)) begin miscompares++; $display("FAIL inject_ack: got err %0d want 2", err_cnt); end
    do_cmd(OP_READ, 0, 4, 1'b0, 1'b0);
    vectors++;
    if (err_cnt !== CNT_W'(2) || ovf_cnt !== '0 || udf_cnt !== '0) begin
      miscompares++; $display("FAIL inject_after: got err %0d ovf %0d udf %0d want 2 0 0", err_cnt, ovf_cnt, udf_cnt);
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic frc;
    int w, r, free;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      frc = ($urandom_range(0, 3) == 0);
      w = $urandom_range(0, 12);
      r = $urandom_range(0, 12);
      free = DEPTH - m_cnt;
      if (!frc) begin
        if (op == OP_WRITE && w > free) w = free;
        if (op == OP_READ && r > m_cnt) r = m_cnt;
        if (op == OP_MIXED) begin
          if (r > m_cnt + w) r = m_cnt + w;
          if (w > free + r) w = free + r;
        end
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      do_cmd(op, w, r, frc, 1'b1);
      vectors++;
      if (obs_dn != 1 || obs_wc != exp_w || obs_rc != exp_r) begin
        miscompares++;
        $display("FAIL rnd%0d_reqs: got done %0d wr %0d rd %0d want 1 %0d %0d", t, obs_dn, obs_wc, obs_rc, exp_w, exp_r);
      end
      vectors++;
      if (wlog.size() != exp_aw) begin
        miscompares++; $display("FAIL rnd%0d_wcount: got %0d want %0d", t, wlog.size(), exp_aw);
      end
      for (int k = 0; k < wlog.size() && k < exp_aw; k++) begin
        vectors++;
        if (wlog[k] !== wr_base + W'(k)) begin
          miscompares++; $display("FAIL rnd%0d_wdata[%0d]: got %h want %h", t, k, wlog[k], wr_base + W'(k));
        end
      end
      vectors++;
      if (data_in !== m_wr) begin miscompares++; $display("FAIL rnd%0d_wr_pat: got %h want %h", t, data_in, m_wr); end
      vectors++;
      if (err_cnt !== CNT_W'(m_err) || ovf_cnt !== CNT_W'(m_ovf) || udf_cnt !== CNT_W'(m_udf)) begin
        miscompares++;
        $display("FAIL rnd%0d_counters: got err %0d ovf %0d udf %0d want %0d %0d %0d",
                 t, err_cnt, ovf_cnt, udf_cnt, m_err, m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_write_read();
    test_mixed();
    test_force_overflow();
    test_force_underflow_nop();
    test_fault_inject();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
